raster_cmd_queue: RTL and testbench
===================================

Name: raster_cmd_queue

Overview:
- Command queue and dispatcher between the CPU and the rasterizer.
- Buffers up to DEPTH draw commands pushed by the CPU, so the CPU never waits on rasterizer busy.
- Feeds the commands one at a time to the rasterizer's execute_request/busy handshake and guarantees execute_request is never asserted while the rasterizer is busy.
- Sits directly in front of the rasterizer.

Parameters:
- DEPTH, 8: number of FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  50MHz system clock
- rst_async  in  1  asynchronous active-high reset
- cmd_push  in  1  CPU pushes one command this cycle
- cmd_command  in  8  command_t opcode
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  8 each  coordinates
- cmd_colour  in  3  colour
- cmd_flush  in  1  discard all queued (not yet issued) commands
- cmd_full  out  1  FIFO holds DEPTH entries
- cmd_count  out  $clog2(DEPTH)+1  number of queued entries
- cmd_overflow  out  1  sticky: a push was dropped
- idle  out  1  queue empty, no command in flight, rasterizer not busy
- ras_command  out  8  command_t to rasterizer
- ras_x0, ras_y0, ras_x1, ras_y1  out  8 each  coordinates to rasterizer
- ras_colour  out  3  colour to rasterizer
- ras_execute_request  out  1  one-cycle start pulse
- ras_busy  in  1  rasterizer busy flag

Behaviour:
- Reset values: ras_execute_request 0, ras_command NOP, other ras_* fields 0, cmd_full 0, cmd_count 0, cmd_overflow 0, idle 1, FSM in IDLE, FIFO pointers 0.
- All ras_* outputs are registered.
- FIFO entry: {command, x0, y0, x1, y1, colour}, 43 bits.
- FIFO is first-word-fall-through. A push at edge k is visible in cmd_count after edge k.
- Push while full (cmd_count==DEPTH) is dropped and sets cmd_overflow. This holds even if a pop occurs in the same cycle.
- Push while not full and a pop in the same cycle: both take effect, and cmd_count is unchanged.
- Pointers wrap modulo DEPTH. cmd_count is computed from pointers with an extra wrap bit; full and empty are derived from cmd_count.
- FSM states:
  - IDLE: if count>0 and !ras_busy, load the head entry into the ras_* registers and go to ISSUE.
  - ISSUE: ras_execute_request=1 for exactly this cycle. Pop the head at the end of the cycle, then go to ARMED.
  - ARMED: ras_busy is guaranteed high this cycle because the rasterizer latches busy one edge after the request. ras_busy is ignored; go to WAIT.
  - WAIT: stay while ras_busy=1. When ras_busy=0 and count>0, load the head and go to ISSUE. When ras_busy=0 and count==0, go to IDLE.
- Latency:
  - Push in cycle k into an empty, idle queue: ras_execute_request is high in cycle k+2.
  - Minimum spacing between requests is 3 cycles (a NOP back-to-back case).
- ras_* fields hold the last issued command until the next load, so the rasterizer may sample them at any time during execution.
- cmd_flush (synchronous):
  - Resets the FIFO pointers and clears cmd_overflow at the next edge.
  - Does not abort an in-flight command; the FSM completes ARMED/WAIT normally.
  - Flush during ISSUE: the pulse still completes and the pop is suppressed; the pointers reset.
  - Flush with a push in the same cycle: flush wins and the push is dropped, without setting overflow.
- idle = (state==IDLE) & (count==0) & !ras_busy, combinational.
- An asynchronous reset mid-operation returns everything to the reset values. The rasterizer shares rst_async, so no handshake recovery is needed.
- Opcodes are not decoded. Unknown opcodes are forwarded unchanged.

Decomposition:
- Shared package gpu_pkg holds:
  - command_t (NOP=0, FILL=1, POINT=2, 8-bit)
  - FB_WIDTH=214, FB_HEIGHT=160
  - raster_cmd_t: the packed struct for the FIFO entry
- The rasterizer moves to gpu_pkg::command_t.
- One sub-module: raster_cmd_fifo, a parameterised FWFT FIFO with push/pop/flush/count/full/empty/overflow, width set by $bits(raster_cmd_t).
- The FSM and output registers live in raster_cmd_queue.

Test Plan:
- Reset release, then push POINT x0=5 y0=7 colour=3 in cycle 0 with ras_busy=0.
  - Required: ras_execute_request high only in cycle 2, with ras_x0=5, ras_y0=7, ras_colour=3.
  - Required: cmd_count returns to 0 after cycle 2.
- Push 3 NOPs in consecutive cycles, using a rasterizer model where busy rises 1 cycle after the request and falls 1 cycle later.
  - Required: 3 request pulses spaced exactly 3 cycles apart.
  - Required: never a pulse while ras_busy=1; idle=1 after the last command.
- Push FILL, hold ras_busy=1 for 100 cycles, and push 8 more commands meanwhile (DEPTH=8).
  - Required: cmd_full=1 with cmd_count=8.
  - Required: the 9th push sets cmd_overflow=1 and is not queued; the order of later issued commands is preserved.
- Push 4 commands, then assert cmd_flush during WAIT with a push in the same cycle.
  - Required: cmd_count=0 and cmd_overflow=0 the next cycle.
  - Required: no further request pulses after busy falls; the simultaneous push is discarded.
- Assert rst_async in the middle of ARMED with 3 entries queued.
  - Required: all outputs take their reset values immediately, without waiting for a clock edge.
  - Required: after reset release with no pushes, no request pulse for 20 cycles.
- Push 20 commands with DEPTH=8, paced so the FIFO never overflows.
  - Required: the issued sequence matches the push sequence exactly across pointer wrap-around.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: command opcodes, framebuffer geometry and the queued draw-command record
package gpu_pkg;
    typedef enum logic [7:0] {NOP = 8'd0, FILL = 8'd1, POINT = 8'd2} command_t;
    localparam int FB_WIDTH = 214;
    localparam int FB_HEIGHT = 160;
    typedef struct packed {
        command_t   command;
        logic [7:0] x0;
        logic [7:0] y0;
        logic [7:0] x1;
        logic [7:0] y1;
        logic [2:0] colour;
    } raster_cmd_t;
endpackage

// File: rtl/raster_cmd_fifo.sv
// raster_cmd_fifo: first-word-fall-through FIFO with flush and sticky overflow
module raster_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 43
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic             r_overflow;
    logic             w_wr_en, w_rd_en;
    // the extra pointer bit separates full from empty
    assign o_count    = r_wr_ptr - r_rd_ptr;
    assign o_full     = o_count == (AW+1)'(DEPTH);
    assign o_empty    = o_count == '0;
    assign o_overflow = r_overflow;
    assign o_data     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr_en    = i_push & ~o_full & ~i_flush;
    assign w_rd_en    = i_pop & ~o_empty & ~i_flush;
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + (AW+1)'(w_wr_en);
            r_rd_ptr   <= r_rd_ptr + (AW+1)'(w_rd_en);
            r_overflow <= r_overflow | (i_push & o_full);
        end
    end
endmodule

// File: rtl/raster_cmd_queue.sv
// raster_cmd_queue: buffers CPU draw commands and issues them one at a time
// to the rasterizer, never requesting while it is busy
module raster_cmd_queue #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic                   cmd_push,
    input  logic [7:0]             cmd_command,
    input  logic [7:0]             cmd_x0,
    input  logic [7:0]             cmd_y0,
    input  logic [7:0]             cmd_x1,
    input  logic [7:0]             cmd_y1,
    input  logic [2:0]             cmd_colour,
    input  logic                   cmd_flush,
    output logic                   cmd_full,
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic                   cmd_overflow,
    output logic                   idle,
    output logic [7:0]             ras_command,
    output logic [7:0]             ras_x0,
    output logic [7:0]             ras_y0,
    output logic [7:0]             ras_x1,
    output logic [7:0]             ras_y1,
    output logic [2:0]             ras_colour,
    output logic                   ras_execute_request,
    input  logic                   ras_busy
);
    import gpu_pkg::*;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARMED, S_WAIT} state_t;
    state_t      r_state;
    raster_cmd_t r_ras, w_head, w_push_data;
    logic        r_req, w_empty, w_load;
    assign w_push_data = '{command: command_t'(cmd_command), x0: cmd_x0, y0: cmd_y0,
                           x1: cmd_x1, y1: cmd_y1, colour: cmd_colour};
    raster_cmd_fifo #(.DEPTH(DEPTH), .WIDTH($bits(raster_cmd_t))) u_fifo (
        .clk        (clk),
        .rst_async  (rst_async),
        .i_push     (cmd_push),
        .i_data     (w_push_data),
        .i_pop      (r_state == S_ISSUE),
        .i_flush    (cmd_flush),
        .o_data     (w_head),
        .o_count    (cmd_count),
        .o_full     (cmd_full),
        .o_empty    (w_empty),
        .o_overflow (cmd_overflow)
    );
    // a head entry flushed in the same cycle counts as never issued
    assign w_load = ~w_empty & ~ras_busy & ~cmd_flush & (r_state == S_IDLE | r_state == S_WAIT);
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state <= S_IDLE;
            r_ras   <= '0;
            r_req   <= 1'b0;
        end else begin
            r_req   <= w_load;
            if (w_load) r_ras <= w_head;
            r_state <= w_load                        ? S_ISSUE :
                       r_state == S_ISSUE            ? S_ARMED :
                       r_state == S_ARMED            ? S_WAIT  :
                       (r_state == S_WAIT & ~ras_busy) ? S_IDLE  : r_state;
        end
    end
    assign ras_execute_request = r_req;
    assign ras_command         = r_ras.command;
    assign ras_x0              = r_ras.x0;
    assign ras_y0              = r_ras.y0;
    assign ras_x1              = r_ras.x1;
    assign ras_y1              = r_ras.y1;
    assign ras_colour          = r_ras.colour;
    assign idle                = (r_state == S_IDLE) & w_empty & ~ras_busy;
endmodule

// File: tb/tb_raster_cmd_queue.sv
// tb_raster_cmd_queue: directed, table-driven bench for raster_cmd_queue
// with a simple rasterizer busy model
module tb_raster_cmd_queue;
    logic       clk = 1'b0, rst_async = 1'b1;
    logic       cmd_push = 1'b0, cmd_flush = 1'b0;
    logic [7:0] cmd_command = '0, cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [2:0] cmd_colour = '0;
    logic       cmd_full, cmd_overflow, idle, ras_execute_request, ras_busy;
    logic [3:0] cmd_count;
    logic [7:0] ras_command, ras_x0, ras_y0, ras_x1, ras_y1;
    logic [2:0] ras_colour;

    int n_chk = 0, n_fail = 0, cyc = 0, busy_len = 1, busy_cnt = 0, busy_viol = 0;
    logic busy_force = 1'b0;

    typedef struct {int cyc; logic [42:0] f;} pulse_t;
    pulse_t pulses[$];

    typedef struct {
        logic push; logic req; logic [3:0] count; logic idl;
        logic [7:0] x0; logic [7:0] y0; logic [2:0] col;
    } vec_t;
    vec_t vt[6];
    logic [42:0] seq[20];

    raster_cmd_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst_async(rst_async), .cmd_push(cmd_push), .cmd_command(cmd_command),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_colour(cmd_colour), .cmd_flush(cmd_flush), .cmd_full(cmd_full),
        .cmd_count(cmd_count), .cmd_overflow(cmd_overflow), .idle(idle),
        .ras_command(ras_command), .ras_x0(ras_x0), .ras_y0(ras_y0), .ras_x1(ras_x1),
        .ras_y1(ras_y1), .ras_colour(ras_colour),
        .ras_execute_request(ras_execute_request), .ras_busy(ras_busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // rasterizer: busy rises one edge after the request and lasts busy_len cycles
    always @(posedge clk or posedge rst_async)
        if (rst_async) busy_cnt <= 0;
        else if (ras_execute_request) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    assign ras_busy = busy_force | (busy_cnt > 0);

    always @(negedge clk)
        if (ras_execute_request) begin
            if (ras_busy) busy_viol++;
            pulses.push_back('{cyc, {ras_command, ras_x0, ras_y0, ras_x1, ras_y1, ras_colour}});
        end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [42:0] mk(input int c, input int a, input int b, input int d, input int e, input int col);
        return {8'(c), 8'(a), 8'(b), 8'(d), 8'(e), 3'(col)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [42:0] e);
        cmd_push = 1'b1;
        {cmd_command, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour} = e;
        step();
        cmd_push = 1'b0;
    endtask

    task automatic wait_pulses(input string nm, input int n, input int budget);
        int t = 0;
        while (pulses.size() < n && t < budget) begin
            step();
            t++;
        end
        chk(nm, 64'(pulses.size()), 64'(n));
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 4'd0, 1'b1, 8'd0, 8'd0, 3'd0};
        vt[1] = '{1'b0, 1'b0, 4'd1, 1'b0, 8'd0, 8'd0, 3'd0};
        vt[2] = '{1'b0, 1'b1, 4'd1, 1'b0, 8'd5, 8'd7, 3'd3};
        vt[3] = '{1'b0, 1'b0, 4'd0, 1'b0, 8'd5, 8'd7, 3'd3};
        vt[4] = '{1'b0, 1'b0, 4'd0, 1'b0, 8'd5, 8'd7, 3'd3};
        vt[5] = '{1'b0, 1'b0, 4'd0, 1'b1, 8'd5, 8'd7, 3'd3};
        for (int i = 0; i < 20; i++)
            seq[i] = mk((i % 4 == 3) ? 8'hC0 + i : i % 3, i * 3, i + 100, 200 - i, i, i % 8);

        repeat (3) @(posedge clk);
        #1 rst_async = 1'b0;
        @(negedge clk);
        chk("rst_req", 64'(ras_execute_request), 0);
        chk("rst_cmd", 64'(ras_command), 0);
        chk("rst_count", 64'(cmd_count), 0);
        chk("rst_full", 64'(cmd_full), 0);
        chk("rst_ovf", 64'(cmd_overflow), 0);
        chk("rst_idle", 64'(idle), 1);
        step();

        // single POINT: request exactly two cycles after the push
        for (int i = 0; i < 6; i++) begin
            cmd_push = vt[i].push;
            {cmd_command, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour} = mk(2, 5, 7, 0, 0, 3);
            @(negedge clk);
            chk($sformatf("t1_req_c%0d", i), 64'(ras_execute_request), 64'(vt[i].req));
            chk($sformatf("t1_count_c%0d", i), 64'(cmd_count), 64'(vt[i].count));
            chk($sformatf("t1_idle_c%0d", i), 64'(idle), 64'(vt[i].idl));
            chk($sformatf("t1_x0_c%0d", i), 64'(ras_x0), 64'(vt[i].x0));
            chk($sformatf("t1_y0_c%0d", i), 64'(ras_y0), 64'(vt[i].y0));
            chk($sformatf("t1_col_c%0d", i), 64'(ras_colour), 64'(vt[i].col));
            step();
        end
        cmd_push = 1'b0;

        // three back-to-back NOPs
        pulses.delete();
        repeat (3) push(mk(0, 0, 0, 0, 0, 0));
        wait_pulses("t2_pulses", 3, 50);
        if (pulses.size() == 3) begin
            chk("t2_gap01", 64'(pulses[1].cyc - pulses[0].cyc), 3);
            chk("t2_gap12", 64'(pulses[2].cyc - pulses[1].cyc), 3);
        end
        repeat (5) step();
        chk("t2_idle", 64'(idle), 1);

        // fill while the rasterizer is busy on a long FILL
        busy_len = 100;
        pulses.delete();
        push(mk(1, 8'hA0, 0, 0, 0, 1));
        wait_pulses("t3_fill_issue", 1, 20);
        for (int i = 1; i <= 8; i++) push(mk(2, i, 0, 0, 0, i % 8));
        chk("t3_count8", 64'(cmd_count), 8);
        chk("t3_full", 64'(cmd_full), 1);
        chk("t3_ovf_before", 64'(cmd_overflow), 0);
        push(mk(2, 9, 0, 0, 0, 1));
        chk("t3_ovf", 64'(cmd_overflow), 1);
        chk("t3_count_after", 64'(cmd_count), 8);
        busy_len = 1;
        wait_pulses("t3_drain", 9, 400);
        repeat (10) step();
        chk("t3_total", 64'(pulses.size()), 9);
        if (pulses.size() >= 1) chk("t3_first_cmd", 64'(pulses[0].f[42:35]), 1);
        for (int i = 1; i < pulses.size() && i < 9; i++)
            chk($sformatf("t3_order%0d", i), 64'(pulses[i].f[34:27]), 64'(i));

        // flush during WAIT, with a simultaneous push
        busy_len = 20;
        pulses.delete();
        for (int i = 0; i < 4; i++) push(mk(2, 8'h40 + i, 0, 0, 0, 2));
        chk("t4_count_pre", 64'(cmd_count), 3);
        cmd_flush = 1'b1;
        cmd_push = 1'b1;
        {cmd_command, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour} = mk(2, 8'h77, 0, 0, 0, 4);
        step();
        cmd_flush = 1'b0;
        cmd_push = 1'b0;
        chk("t4_count_post", 64'(cmd_count), 0);
        chk("t4_ovf_post", 64'(cmd_overflow), 0);
        repeat (40) step();
        chk("t4_pulses", 64'(pulses.size()), 1);
        if (pulses.size() >= 1) chk("t4_first_x0", 64'(pulses[0].f[34:27]), 8'h40);
        chk("t4_idle", 64'(idle), 1);

        // asynchronous reset while ARMED with three entries queued
        busy_force = 1'b1;
        pulses.delete();
        for (int i = 0; i < 4; i++) push(mk(2, 8'h50 + i, 8'h11, 8'h22, 8'h33, 5));
        busy_force = 1'b0;
        wait_pulses("t5_issue", 1, 10);
        chk("t5_count_armed", 64'(cmd_count), 3);
        chk("t5_x0_armed", 64'(ras_x0), 8'h50);
        rst_async = 1'b1;
        #2;
        chk("t5_req", 64'(ras_execute_request), 0);
        chk("t5_cmd", 64'(ras_command), 0);
        chk("t5_fields", 64'({ras_x0, ras_y0, ras_x1, ras_y1, ras_colour}), 0);
        chk("t5_count", 64'(cmd_count), 0);
        chk("t5_full", 64'(cmd_full), 0);
        chk("t5_ovf", 64'(cmd_overflow), 0);
        chk("t5_idle", 64'(idle), 1);
        @(negedge clk);
        rst_async = 1'b0;
        pulses.delete();
        repeat (20) step();
        chk("t5_no_pulse", 64'(pulses.size()), 0);

        // twenty paced commands across pointer wrap-around
        busy_len = 1;
        pulses.delete();
        for (int i = 0; i < 20; i++) begin
            push(seq[i]);
            step();
            step();
        end
        wait_pulses("t6_pulses", 20, 100);
        for (int i = 0; i < pulses.size() && i < 20; i++)
            chk($sformatf("t6_entry%0d", i), 64'(pulses[i].f), 64'(seq[i]));
        chk("t6_ovf", 64'(cmd_overflow), 0);
        chk("busy_violations", 64'(busy_viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
